// File: rtl/led_fade_pwm.sv
// Per-channel PWM LED driver: a lit pattern bit loads full brightness, a cleared bit
// fades linearly to off, leaving a trailing comet behind the rotating pattern.
module led_fade_pwm #(
  parameter int PWM_BITS   = 8,
  parameter int DECAY_DIV  = 31_250,
  parameter int DECAY_STEP = 8
) (
  input  logic       clk1MHz,
  input  logic       rst,
  input  logic [7:0] pattern_in,
  input  logic       en,
  output logic [7:0] led_out,
  output logic       frame_start
);

  localparam int DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [PWM_BITS-1:0] LVL_MAX    = '1;
  localparam logic [PWM_BITS-1:0] STEP       = PWM_BITS'(DECAY_STEP);
  localparam logic [DW-1:0]       DECAY_LAST = DW'(DECAY_DIV - 1);

  logic [7:0]          p_m;
  logic [7:0]          p_s;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [DW-1:0]       decay_cnt;
  logic                tick;
  logic [PWM_BITS-1:0] level     [8];
  logic [PWM_BITS-1:0] level_nxt [8];
  logic [PWM_BITS-1:0] duty      [8];
  logic [7:0]          led_nxt;

  assign tick = (decay_cnt == DECAY_LAST);

  // Load beats decay; a fading level saturates at zero instead of wrapping.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      level_nxt[i] = level[i];
      if (!en)
        level_nxt[i] = '0;
      else if (p_s[i])
        level_nxt[i] = LVL_MAX;
      else if (tick && level[i] >= STEP)
        level_nxt[i] = level[i] - STEP;
      else if (tick)
        level_nxt[i] = '0;
    end
  end

  always_comb begin
    led_nxt = '0;
    for (int i = 0; i < 8; i++)
      led_nxt[i] = en && ((duty[i] == LVL_MAX) || (pwm_cnt < duty[i]));
  end

  always_ff @(posedge clk1MHz or posedge rst) begin
    if (rst) begin
      p_m         <= '0;
      p_s         <= '0;
      pwm_cnt     <= '0;
      decay_cnt   <= '0;
      led_out     <= '0;
      frame_start <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        level[i] <= '0;
        duty[i]  <= '0;
      end
    end else begin
      p_m         <= pattern_in;
      p_s         <= p_m;
      pwm_cnt     <= pwm_cnt + PWM_BITS'(1);
      decay_cnt   <= tick ? '0 : decay_cnt + DW'(1);
      frame_start <= (pwm_cnt == '0);
      led_out     <= led_nxt;
      for (int i = 0; i < 8; i++) begin
        level[i] <= level_nxt[i];
        // Duty only moves at the period boundary so a period is never split.
        if (pwm_cnt == LVL_MAX)
          duty[i] <= level[i];
      end
    end
  end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Bench for led_fade_pwm: a time-based brightness model predicts the on-count of every
// channel for each PWM period; a monitor counts led_out over each frame_start period.
module tb_led_fade_pwm;

  localparam int DIV  = 97;
  localparam int STEP = 8;

  logic       clk1MHz = 1'b0;
  logic       rst     = 1'b1;
  logic [7:0] pattern_in = '0;
  logic       en = 1'b0;
  logic [7:0] led_out;
  logic       frame_start;

  int n_cmp  = 0;
  int n_fail = 0;

  led_fade_pwm #(.PWM_BITS(8), .DECAY_DIV(DIV), .DECAY_STEP(STEP)) dut (
    .clk1MHz    (clk1MHz),
    .rst        (rst),
    .pattern_in (pattern_in),
    .en         (en),
    .led_out    (led_out),
    .frame_start(frame_start)
  );

  always #500 clk1MHz = ~clk1MHz;

  // ---------------- reference model ----------------
  // Brightness at edge m = 255 - STEP * (ticks since the last load), floored at 0.
  // Ticks fall on edges that are multiples of DIV, counting edges from reset release.
  logic [72:0] exp_q[$];
  int          edge_n = 0;
  int          pushed = 0;
  int          popped = 0;
  logic [7:0]  hist1, hist2;
  logic [7:0]  has_load;
  int          last_load [8];
  int          duty_m    [8];
  logic        en_all1, en_all0;

  function automatic int lvl(int ch, int m);
    int t;
    if (!has_load[ch]) return 0;
    t = m / DIV - last_load[ch] / DIV;
    return (255 - STEP * t < 0) ? 0 : 255 - STEP * t;
  endfunction

  always @(posedge clk1MHz) begin
    logic [72:0] e;
    logic [7:0]  ps;
    int          c;
    if (rst) begin
      edge_n = 0;
      hist1 = '0;
      hist2 = '0;
      has_load = '0;
      for (int i = 0; i < 8; i++) begin
        duty_m[i] = 0;
        last_load[i] = 0;
      end
      en_all1 = 1'b1;
      en_all0 = 1'b1;
      pushed = pushed - exp_q.size();
      exp_q.delete();
    end else begin
      edge_n++;
      en_all1 = en_all1 & en;
      en_all0 = en_all0 & !en;
      if (edge_n % 256 == 0) begin
        e = '0;
        if (!en_all1 && !en_all0) e[72] = 1'b1;
        else
          for (int i = 0; i < 8; i++) begin
            c = en_all1 ? ((duty_m[i] == 255) ? 256 : duty_m[i]) : 0;
            e[i*9 +: 9] = 9'(c);
          end
        exp_q.push_back(e);
        pushed++;
        for (int i = 0; i < 8; i++) duty_m[i] = lvl(i, edge_n - 1);
        en_all1 = 1'b1;
        en_all0 = 1'b1;
      end
      ps = hist2;
      for (int i = 0; i < 8; i++) begin
        if (!en) has_load[i] = 1'b0;
        else if (ps[i]) begin
          has_load[i] = 1'b1;
          last_load[i] = edge_n;
        end
      end
      hist2 = hist1;
      hist1 = pattern_in;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int   mon_cnt = 0;
  logic mon_active = 1'b0;
  int   hi_cnt [8];

  always @(negedge clk1MHz) begin
    logic [72:0] e;
    logic [71:0] act;
    if (rst) begin
      mon_active = 1'b0;
      mon_cnt = 0;
    end else begin
      if (frame_start) begin
        if (mon_active) begin
          n_cmp++;
          n_fail++;
          $display("FAIL frame_spacing: frame_start after %0d cycles, required 256", mon_cnt);
        end
        mon_active = 1'b1;
        mon_cnt = 0;
        for (int i = 0; i < 8; i++) hi_cnt[i] = 0;
      end
      if (mon_active) begin
        for (int i = 0; i < 8; i++) hi_cnt[i] += int'(led_out[i]);
        mon_cnt++;
        if (mon_cnt == 256) begin
          mon_active = 1'b0;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL period_queue: period ended at edge %0d with no expectation", edge_n);
          end else begin
            e = exp_q.pop_front();
            popped++;
            if (!e[72]) begin
              for (int i = 0; i < 8; i++) act[i*9 +: 9] = 9'(hi_cnt[i]);
              n_cmp++;
              if (act !== e[71:0]) begin
                n_fail++;
                $display("FAIL period_on_counts @edge %0d: actual %h required %h",
                         edge_n, act, e[71:0]);
              end
            end
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic wait_cyc(input int k);
    repeat (k) @(negedge clk1MHz);
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  initial begin
    // reset state
    wait_cyc(3);
    check8("reset_led_out", led_out, 8'h00);
    check8("reset_frame_start", {7'd0, frame_start}, 8'h00);
    rst = 1'b0;
    en  = 1'b1;
    wait_cyc(1);
    check8("first_frame_start", {7'd0, frame_start}, 8'h01);

    // single channel solid on, then full fade with saturation at zero
    pattern_in = 8'h01;
    wait_cyc(600);
    check8("ch0_solid_on", led_out, 8'h01);
    pattern_in = 8'h00;
    wait_cyc(32 * DIV + 600);
    check8("ch0_faded_off", led_out, 8'h00);

    // one-cycle pulse whose load lands on a tick edge
    for (int k = 0; k < DIV && ((edge_n + 3) % DIV != 0); k++) wait_cyc(1);
    check8("pulse_alignment", 8'((edge_n + 3) % DIV), 8'h00);
    pattern_in = 8'h10;
    wait_cyc(1);
    pattern_in = 8'h00;
    wait_cyc(1200);

    // all on, enable drop and recovery
    pattern_in = 8'hFF;
    wait_cyc(600);
    check8("all_solid_on", led_out, 8'hFF);
    en = 1'b0;
    wait_cyc(1);
    check8("en_drop_blank", led_out, 8'h00);
    wait_cyc(300);
    check8("en_low_blank", led_out, 8'h00);
    en = 1'b1;
    wait_cyc(520);
    check8("en_restore_on", led_out, 8'hFF);

    // reset in the middle of a fade
    pattern_in = 8'h00;
    wait_cyc(700);
    rst = 1'b1;
    wait_cyc(1);
    check8("midfade_reset_led", led_out, 8'h00);
    check8("midfade_reset_fs", {7'd0, frame_start}, 8'h00);
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(1);
    check8("post_reset_fs", {7'd0, frame_start}, 8'h01);
    check8("post_reset_no_glow", led_out, 8'h00);

    // randomized patterns, pulses and enable toggles
    for (int seg = 0; seg < 30; seg++) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) begin
        pattern_in = 8'($urandom_range(0, 255));
        wait_cyc($urandom_range(1, 4));
        pattern_in = 8'h00;
      end else begin
        pattern_in = 8'($urandom_range(0, 255));
      end
      wait_cyc($urandom_range(100, 1500));
    end
    pattern_in = 8'h00;
    en = 1'b1;
    wait_cyc(600);

    n_cmp++;
    if (pushed - popped > 1 || pushed < 100) begin
      n_fail++;
      $display("FAIL period_coverage: actual %0d periods checked of %0d predicted", popped, pushed);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
